axi_mst_rd_initiator: RTL and testbench
=======================================

AXI_MST_RD_INITIATOR -- requirements
Module: axi_mst_rd_initiator

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, 32, address width.
REQ-002 SHALL have parameter AXI_ID_W, 4, ID width.
REQ-003 SHALL have parameter AXI_DATA_W, 32, read data width.
REQ-004 SHALL have parameter OSTD_NUM, 4, max outstanding reads; power of 2, >=2.
REQ-005 SHALL have port aclk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid  in  1  read command request.
REQ-008 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 SHALL have port cmd_addr  in  AXI_ADDR_W  burst start address.
REQ-010 SHALL have port cmd_len  in  4  burst length minus one.
REQ-011 SHALL have port cmd_id  in  AXI_ID_W  transaction ID.
REQ-012 SHALL have port arvalid  out  1  AR valid.
REQ-013 SHALL have port arready  in  1  AR ready.
REQ-014 SHALL have port araddr  out  AXI_ADDR_W  AR address.
REQ-015 SHALL have port arlen  out  4  AR length.
REQ-016 SHALL have port arid  out  AXI_ID_W  AR ID.
REQ-017 SHALL have port rvalid  in  1  R valid.
REQ-018 SHALL have port rready  out  1  R ready.
REQ-019 SHALL have port rid  in  AXI_ID_W  R ID.
REQ-020 SHALL have port rresp  in  2  R response.
REQ-021 SHALL have port rdata  in  AXI_DATA_W  R data; accepted, not checked.
REQ-022 SHALL have port rlast  in  1  R last beat.
REQ-023 SHALL have port rd_ostd  out  clog2(OSTD_NUM)+1  outstanding burst count.
REQ-024 SHALL have port rd_done  out  1  one-cycle pulse per completed burst.
REQ-025 SHALL have port err  out  4  sticky error flags.

Function
REQ-026 SHALL drive cmd_ready = (rd_ostd < OSTD_NUM) && !arvalid.
REQ-027 SHALL, on cmd handshake, register addr/len/id onto araddr/arlen/arid and assert arvalid next cycle; payload stable until arready.
REQ-028 SHALL deassert arvalid the cycle after the AR handshake; at most one AR pending.
REQ-029 SHALL push {cmd_len, cmd_id} into a tracking FIFO of depth OSTD_NUM at cmd handshake; pointers wrap modulo OSTD_NUM.
REQ-030 SHALL increment rd_ostd on cmd handshake, decrement on R handshake with rlast, hold when both occur in one cycle.
REQ-031 SHALL drive rready = (rd_ostd != 0).
REQ-032 SHALL keep a 4-bit beat counter: +1 per R handshake, cleared to 0 on R handshake with rlast.
REQ-033 SHALL pop FIFO head and pulse rd_done (registered, 1 cycle after) on R handshake with rlast.
REQ-034 SHALL set err[0] on R handshake where rlast != (beat_cnt == head.len).
REQ-035 SHALL set err[1] on R handshake where rid != head.id; err[2] where rresp != OKAY; err[3] on R handshake with FIFO empty.
REQ-036 SHALL keep err bits set until reset; errors SHALL NOT stall the protocol.
REQ-037 SHALL, on err[0] with rlast=1 early, still pop head and clear beat counter (rlast is authoritative).

Reset
REQ-038 SHALL on aresetn low clear arvalid, araddr, arlen, arid, rd_ostd, rd_done, err, beat counter, FIFO pointers; cmd_ready SHALL read 1 after reset.
REQ-039 SHALL abandon in-flight bursts on reset mid-operation; no pending state survives.

Structure
REQ-040 SHALL take RESP_OKAY constant, err bit index constants and packed struct rd_trk_t {len, id} from shared package axi_tb_pkg.
REQ-041 SHALL instantiate sub-module sync_fifo (parameterised width/depth, full/empty flags) for tracking.

Verification
REQ-042 Single cmd len=3 id=5, arready=1, slave returns 4 beats id=5 OKAY rlast on 4th -> rd_done one pulse, rd_ostd 1->0, err=0.
REQ-043 Issue 4 cmds len=0 with rvalid held 0 -> rd_ostd=4, cmd_ready=0; 5th cmd stalls until first rlast.
REQ-044 Cmd accept and rlast handshake in same cycle with rd_ostd=2 -> rd_ostd stays 2.
REQ-045 len=2 burst, slave asserts rlast on beat 1 -> err[0]=1, head popped, next burst checked normally.
REQ-046 rid=7 vs expected 3, rresp=2'b10 -> err[1]=err[2]=1 sticky; unsolicited R beat at rd_ostd=0 -> err[3]=1 (force rready via bind).
REQ-047 aresetn low mid-burst (beat 2 of 8) -> all outputs zero next edge, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_tb_pkg.sv
// Shared types and constants for the AXI read initiator: response codes,
// error flag bit positions and the per-burst tracking record.
package axi_tb_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Bit positions inside the sticky err vector
  localparam int ERR_LAST  = 0;  // rlast disagrees with expected beat count
  localparam int ERR_ID    = 1;  // rid differs from the oldest outstanding id
  localparam int ERR_RESP  = 2;  // non-OKAY response
  localparam int ERR_EMPTY = 3;  // R beat accepted with nothing outstanding

  // The id field is sized for the widest id we expect; narrower ids are
  // zero-extended on the way in so the record layout never changes.
  localparam int TRK_ID_W = 16;

  typedef struct packed {
    logic [3:0]          len;
    logic [TRK_ID_W-1:0] id;
  } rd_trk_t;

  localparam int TRK_W = $bits(rd_trk_t);

  // Build a tracking record from a command's length and (extended) id
  function automatic rd_trk_t make_trk(input logic [3:0] len, input logic [TRK_ID_W-1:0] id);
    rd_trk_t t;
    t.len = len;
    t.id  = id;
    return t;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers for full/empty detection.
// The head entry is presented combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Flags, head read and qualified push/pop
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Next pointers and storage contents; lower pointer bits wrap modulo DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  // Pointer registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: rtl/axi_mst_rd_initiator.sv
// AXI read master front end: turns simple read commands into AR requests,
// tracks outstanding bursts in order, and checks the returning R stream
// against the tracked length/id, raising sticky error flags without stalling.
//
// Handshakes: every channel transfers on a rising edge where valid && ready.
// Valid never waits on ready; once arvalid is high its payload is held
// unchanged until the cycle arready is seen.
module axi_mst_rd_initiator
  import axi_tb_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32,
  parameter int OSTD_NUM   = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [AXI_ADDR_W-1:0]        cmd_addr,
  input  logic [3:0]                   cmd_len,
  input  logic [AXI_ID_W-1:0]          cmd_id,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [AXI_ADDR_W-1:0]        araddr,
  output logic [3:0]                   arlen,
  output logic [AXI_ID_W-1:0]          arid,
  input  logic                         rvalid,
  output logic                         rready,
  input  logic [AXI_ID_W-1:0]          rid,
  input  logic [1:0]                   rresp,
  input  logic [AXI_DATA_W-1:0]        rdata,
  input  logic                         rlast,
  output logic [$clog2(OSTD_NUM):0]    rd_ostd,
  output logic                         rd_done,
  output logic [3:0]                   err
);

  localparam int OSTD_W = $clog2(OSTD_NUM) + 1;

  logic                  arvalid_q, arvalid_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [AXI_ID_W-1:0]   arid_q, arid_d;
  logic [OSTD_W-1:0]     rd_ostd_q, rd_ostd_d;
  logic                  rd_done_q, rd_done_d;
  logic [3:0]            err_q, err_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;

  logic                  cmd_hs;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  last_hs;
  rd_trk_t               trk_wr;
  rd_trk_t               trk_head;
  logic                  trk_empty;
  logic                  trk_full_unused;
  logic                  rdata_unused;

  // Read data is passed through by the slave and not inspected here
  assign rdata_unused = ^rdata;

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arid    = arid_q;
  assign rd_ostd = rd_ostd_q;
  assign rd_done = rd_done_q;
  assign err     = err_q;

  // Ready terms and handshake qualifiers
  always_comb begin
    cmd_ready = (rd_ostd_q < OSTD_W'(OSTD_NUM)) && !arvalid_q;
    rready    = (rd_ostd_q != '0);
    cmd_hs    = cmd_valid && cmd_ready;
    ar_hs     = arvalid_q && arready;
    r_hs      = rvalid && rready;
    last_hs   = r_hs && rlast;
    trk_wr    = make_trk(cmd_len, TRK_ID_W'(cmd_id));
  end

  // Tracking FIFO: one record per accepted command, popped on each rlast
  sync_fifo #(
    .WIDTH (TRK_W),
    .DEPTH (OSTD_NUM)
  ) u_trk_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (cmd_hs),
    .wdata (trk_wr),
    .pop   (last_hs),
    .rdata (trk_head),
    .full  (trk_full_unused),
    .empty (trk_empty)
  );

  // AR channel: load payload on command accept, drop valid after AR handshake
  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arid_d    = arid_q;
    if (cmd_hs) begin
      arvalid_d = 1'b1;
      araddr_d  = cmd_addr;
      arlen_d   = cmd_len;
      arid_d    = cmd_id;
    end else if (ar_hs) begin
      arvalid_d = 1'b0;
    end
  end

  // Outstanding count, beat counter and completion pulse
  always_comb begin
    rd_ostd_d  = rd_ostd_q;
    beat_cnt_d = beat_cnt_q;
    rd_done_d  = last_hs;
    if (cmd_hs && !last_hs) begin
      rd_ostd_d = rd_ostd_q + OSTD_W'(1);
    end else if (!cmd_hs && last_hs && (rd_ostd_q != '0)) begin
      rd_ostd_d = rd_ostd_q - OSTD_W'(1);
    end
    if (r_hs) begin
      // rlast always closes the burst, even when it arrives early
      beat_cnt_d = rlast ? 4'd0 : beat_cnt_q + 4'd1;
    end
  end

  // Sticky protocol checks on every accepted R beat
  always_comb begin
    err_d = err_q;
    if (r_hs) begin
      if (trk_empty) begin
        err_d[ERR_EMPTY] = 1'b1;
      end else begin
        if (rlast != (beat_cnt_q == trk_head.len)) err_d[ERR_LAST] = 1'b1;
        if (TRK_ID_W'(rid) != trk_head.id)         err_d[ERR_ID]   = 1'b1;
      end
      if (rresp != RESP_OKAY) err_d[ERR_RESP] = 1'b1;
    end
  end

  // State registers; reset abandons any bursts in flight
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      rd_ostd_q  <= '0;
      rd_done_q  <= 1'b0;
      err_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arid_q     <= arid_d;
      rd_ostd_q  <= rd_ostd_d;
      rd_done_q  <= rd_done_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_mst_rd_initiator.sv
// Bench for axi_mst_rd_initiator. A transaction-level reference keeps the
// outstanding bursts in a queue and derives every expected output from it.
module tb_axi_mst_rd_initiator;

  localparam int AW   = 32;
  localparam int IW   = 4;
  localparam int DW   = 32;
  localparam int OSTD = 4;

  logic          aclk;
  logic          aresetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [3:0]    arlen;
  logic [IW-1:0] arid;
  logic          rvalid;
  logic          rready;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic [2:0]    rd_ostd;
  logic          rd_done;
  logic [3:0]    err;

  axi_mst_rd_initiator #(
    .AXI_ADDR_W (AW),
    .AXI_ID_W   (IW),
    .AXI_DATA_W (DW),
    .OSTD_NUM   (OSTD)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_id    (cmd_id),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arid      (arid),
    .rvalid    (rvalid),
    .rready    (rready),
    .rid       (rid),
    .rresp     (rresp),
    .rdata     (rdata),
    .rlast     (rlast),
    .rd_ostd   (rd_ostd),
    .rd_done   (rd_done),
    .err       (err)
  );

  // Clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Reference model state
  typedef struct {
    logic [3:0]    len;
    logic [IW-1:0] id;
  } trk_s;

  trk_s          trk_q[$];
  logic          m_ar_pend;
  logic [AW-1:0] m_araddr;
  logic [3:0]    m_arlen;
  logic [IW-1:0] m_arid;
  int            m_beat;
  logic [3:0]    m_err;
  logic          m_done;
  logic          last_cmd_hs;
  logic          last_r_hs;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s timed out", tag);
  endtask

  task automatic model_reset();
    trk_q.delete();
    m_ar_pend = 1'b0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arid    = '0;
    m_beat    = 0;
    m_err     = '0;
    m_done    = 1'b0;
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model
  task automatic cycle();
    logic m_cmd_ready, m_rready, c_hs, a_hs, rh;
    trk_s head;
    @(negedge aclk);
    m_cmd_ready = (trk_q.size() < OSTD) && !m_ar_pend;
    m_rready    = (trk_q.size() != 0);
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_cmd_ready});
    chk("rready",    {31'b0, rready},    {31'b0, m_rready});
    chk("arvalid",   {31'b0, arvalid},   {31'b0, m_ar_pend});
    chk("araddr",    araddr,             m_araddr);
    chk("arlen",     {28'b0, arlen},     {28'b0, m_arlen});
    chk("arid",      {28'b0, arid},      {28'b0, m_arid});
    chk("rd_ostd",   {29'b0, rd_ostd},   trk_q.size());
    chk("rd_done",   {31'b0, rd_done},   {31'b0, m_done});
    chk("err",       {28'b0, err},       {28'b0, m_err});
    c_hs = cmd_valid && m_cmd_ready;
    a_hs = m_ar_pend && arready;
    rh   = rvalid && m_rready;
    @(posedge aclk);
    last_cmd_hs = aresetn && c_hs;
    last_r_hs   = aresetn && rh;
    if (!aresetn) begin
      model_reset();
    end else begin
      m_done = rh && rlast;
      if (rh) begin
        if (trk_q.size() == 0) begin
          m_err[3] = 1'b1;
        end else begin
          head = trk_q[0];
          if (rlast != (m_beat == int'(head.len))) m_err[0] = 1'b1;
          if (rid != head.id) m_err[1] = 1'b1;
        end
        if (rresp != 2'b00) m_err[2] = 1'b1;
        if (rlast) begin
          if (trk_q.size() != 0) void'(trk_q.pop_front());
          m_beat = 0;
        end else begin
          m_beat = (m_beat + 1) % 16;
        end
      end
      if (c_hs) begin
        trk_q.push_back('{len: cmd_len, id: cmd_id});
        m_ar_pend = 1'b1;
        m_araddr  = cmd_addr;
        m_arlen   = cmd_len;
        m_arid    = cmd_id;
      end else if (a_hs) begin
        m_ar_pend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a command until it is accepted
  task automatic send_cmd(input logic [AW-1:0] a, input logic [3:0] l, input logic [IW-1:0] id);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_id    = id;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = last_cmd_hs;
    end
    cmd_valid = 1'b0;
    if (!ok) timeout("send_cmd");
  endtask

  // Present one R beat until it is accepted
  task automatic beat(input logic [IW-1:0] id, input logic [1:0] resp, input logic last);
    bit ok = 0;
    rvalid = 1'b1;
    rid    = id;
    rresp  = resp;
    rlast  = last;
    rdata  = $urandom;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = last_r_hs;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    if (!ok) timeout("beat");
  endtask

  // Return well-formed data for everything outstanding
  task automatic drain_all();
    int guard = 0;
    while (trk_q.size() != 0 && guard < 200) begin
      beat(trk_q[0].id, 2'b00, m_beat == int'(trk_q[0].len));
      guard++;
    end
    if (trk_q.size() != 0) timeout("drain_all");
  endtask

  initial begin
    logic [3:0] id_r;
    checks    = 0;
    errors    = 0;
    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_id    = '0;
    arready   = 1'b1;
    rvalid    = 1'b0;
    rid       = '0;
    rresp     = '0;
    rdata     = '0;
    rlast     = 1'b0;
    last_cmd_hs = 1'b0;
    last_r_hs   = 1'b0;
    model_reset();

    // Reset state
    idle(3);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_ostd", {29'b0, rd_ostd}, 32'd0);
    aresetn = 1'b1;
    idle(2);

    // Single 4-beat burst, id 5
    send_cmd($urandom, 4'd3, 4'd5);
    chk("single_ostd", {29'b0, rd_ostd}, 32'd1);
    for (int b = 0; b < 4; b++) beat(4'd5, 2'b00, b == 3);
    chk("single_done", {31'b0, rd_done}, 32'd1);
    chk("single_ostd0", {29'b0, rd_ostd}, 32'd0);
    idle(1);
    chk("single_done_clr", {31'b0, rd_done}, 32'd0);
    chk("single_err", {28'b0, err}, 32'd0);

    // Fill all outstanding slots, then a fifth command waits for an rlast
    for (int c = 0; c < 4; c++) send_cmd($urandom, 4'd0, 4'($urandom_range(0, 15)));
    idle(2);
    chk("full_ostd", {29'b0, rd_ostd}, 32'd4);
    chk("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    cmd_addr  = $urandom;
    cmd_len   = 4'd0;
    cmd_id    = 4'hA;
    idle(3);
    chk("stall_ostd", {29'b0, rd_ostd}, 32'd4);
    rvalid = 1'b1;
    rid    = trk_q[0].id;
    rresp  = 2'b00;
    rlast  = 1'b1;
    cycle();
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("stall_released_ostd", {29'b0, rd_ostd}, 32'd3);
    cycle();
    cmd_valid = 1'b0;
    chk("stall_accept_ostd", {29'b0, rd_ostd}, 32'd4);
    idle(2);
    drain_all();
    idle(1);

    // Command accept and rlast in the same cycle at two outstanding
    send_cmd($urandom, 4'd0, 4'd1);
    send_cmd($urandom, 4'd0, 4'd2);
    idle(2);
    cmd_valid = 1'b1;
    cmd_addr  = $urandom;
    cmd_len   = 4'd0;
    cmd_id    = 4'd6;
    rvalid    = 1'b1;
    rid       = 4'd1;
    rresp     = 2'b00;
    rlast     = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    chk("simul_ostd", {29'b0, rd_ostd}, 32'd2);
    idle(1);
    drain_all();
    idle(1);
    chk("clean_err", {28'b0, err}, 32'd0);

    // Early rlast on a 3-beat burst, then a well-formed burst
    send_cmd($urandom, 4'd2, 4'd9);
    beat(4'd9, 2'b00, 1'b1);
    chk("early_err", {28'b0, err}, 32'd1);
    chk("early_pop", {29'b0, rd_ostd}, 32'd0);
    send_cmd($urandom, 4'd1, 4'd4);
    beat(4'd4, 2'b00, 1'b0);
    beat(4'd4, 2'b00, 1'b1);
    chk("after_early_err", {28'b0, err}, 32'd1);
    idle(1);

    // Wrong id and SLVERR response
    send_cmd($urandom, 4'd0, 4'd3);
    beat(4'd7, 2'b10, 1'b1);
    chk("id_resp_err", {28'b0, err}, 32'd7);
    idle(3);
    chk("id_resp_sticky", {28'b0, err}, 32'd7);

    // Reset in the middle of an 8-beat burst
    send_cmd($urandom, 4'd7, 4'd2);
    beat(4'd2, 2'b00, 1'b0);
    beat(4'd2, 2'b00, 1'b0);
    rvalid  = 1'b1;
    rid     = 4'd2;
    aresetn = 1'b0;
    #2;
    chk("mid_rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("mid_rst_ostd", {29'b0, rd_ostd}, 32'd0);
    chk("mid_rst_err", {28'b0, err}, 32'd0);
    chk("mid_rst_done", {31'b0, rd_done}, 32'd0);
    chk("mid_rst_araddr", araddr, 32'd0);
    model_reset();
    rvalid = 1'b0;
    idle(2);
    aresetn = 1'b1;
    idle(1);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Randomized traffic with AR backpressure and occasional bad beats
    aresetn = 1'b0;
    idle(1);
    aresetn = 1'b1;
    for (int n = 0; n < 400; n++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_addr  = $urandom;
      cmd_len   = 4'($urandom_range(0, 3));
      cmd_id    = 4'($urandom_range(0, 15));
      arready   = ($urandom_range(0, 3) != 0);
      rvalid    = ($urandom_range(0, 1) != 0);
      rresp     = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'b00;
      rdata     = $urandom;
      if (trk_q.size() != 0) begin
        id_r  = trk_q[0].id;
        rid   = ($urandom_range(0, 15) == 0) ? ~id_r : id_r;
        rlast = (m_beat == int'(trk_q[0].len)) ^ ($urandom_range(0, 15) == 0);
      end else begin
        rid   = 4'($urandom_range(0, 15));
        rlast = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    cmd_valid = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    arready   = 1'b1;
    idle(2);
    drain_all();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
